cacheline_adaptor: RTL

Responder for the data cache's physical-memory port: accepts a 256-bit line read or write request from the cache datapath/control pair (aligned line address, full line write data) and carries it out on a 64-bit burst memory bus as four beats. It sits between the cache's `pmem_*` interface and main memory or the arbiter. It answers each request with a single-cycle `resp_o` once the whole line has been transferred.

---
 rtl/cacheline_adaptor.sv | 86 ++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line read or write into a four-beat 64-bit memory burst.
// It answers the cache with a single-cycle resp_o once the whole line has moved.
module cacheline_adaptor #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int s_offset   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  resp_o,
  output logic [31:0]           address_o,
  output logic                  read_o,
  output logic                  write_o,
  output logic [BEAT_WIDTH-1:0] burst_o,
  input  logic [BEAT_WIDTH-1:0] burst_i,
  input  logic                  resp_i
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [LINE_WIDTH-1:0] wbuf;
  logic                  last_beat;

  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  // Write takes priority over read; resp_i only matters while a burst is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wbuf      <= '0;
      line_o    <= '0;
      address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            wbuf      <= line_i;
            address_o <= address_i & ADDR_MASK;
            cnt       <= '0;
            state     <= WRITE;
          end else if (read_i) begin
            address_o <= address_i & ADDR_MASK;
            cnt       <= '0;
            state     <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= burst_i;
            cnt <= cnt + 1'b1;
            if (last_beat) state <= DONE;
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
            if (last_beat) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only, so memory and cache never form a loop.
  assign read_o  = (state == READ);
  assign write_o = (state == WRITE);
  assign resp_o  = (state == DONE);
  assign burst_o = wbuf[cnt*BEAT_WIDTH +: BEAT_WIDTH];

endmodule
